// File: rtl/trap_seq_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the trap sequencer.
// CSR addresses, cause codes and stall/flush patterns live here so the core agrees on them.
package trap_seq_pkg;

    localparam int XLEN = 64;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int CAUSE_INT_BIT = XLEN - 1;
    localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_MTI   = XLEN'(7);
    localparam logic [XLEN-1:0] CAUSE_MTI_INT = CAUSE_MTI | (XLEN'(1) << CAUSE_INT_BIT);

    localparam logic [5:0] STALL_TRAP     = 6'b001111;
    localparam logic [5:0] FLUSH_REDIRECT = 6'b001110;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_HI   = 12;
    localparam int MPP_LO   = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_TVAL   = 3'd3,
        ST_W_STATUS = 3'd4,
        ST_R_STATUS = 3'd5,
        ST_REDIRECT = 3'd6
    } trap_state_e;

    // Trap entry: interrupts are disabled, the old enable is parked in MPIE, machine mode recorded.
    function automatic logic [XLEN-1:0] entry_status(input logic [XLEN-1:0] snap);
        logic [XLEN-1:0] s;
        s                 = snap;
        s[MPIE_BIT]       = snap[MIE_BIT];
        s[MIE_BIT]        = 1'b0;
        s[MPP_HI:MPP_LO]  = 2'b11;
        return s;
    endfunction

    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] snap);
        logic [XLEN-1:0] s;
        s                 = snap;
        s[MIE_BIT]        = snap[MPIE_BIT];
        s[MPIE_BIT]       = 1'b1;
        s[MPP_HI:MPP_LO]  = 2'b11;
        return s;
    endfunction

endpackage

// File: rtl/trap_seq_target_calc.sv
// Trap vector computation: direct or vectored mtvec, vectored offset applied only to interrupts.
// Reserved modes (2, 3) fall back to direct; the add wraps at XLEN bits.
module trap_target_calc
    import trap_seq_pkg::*;
(
    input  logic [XLEN-1:0] mtvec,
    input  logic            is_irq,
    output logic [XLEN-1:0] target
);

    localparam logic [XLEN-1:0] VEC_OFFSET = CAUSE_MTI << 2;

    logic [XLEN-1:0] base;

    assign base = {mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        target = base;
        if (mtvec[1:0] == 2'b01 && is_irq) begin
            target = base + VEC_OFFSET;
        end
    end

endmodule

// File: rtl/trap_seq.sv
// Multi-cycle trap sequencer: serialises trap entry and mret into CSR writes on the single
// write port, arbitrates that port against CSR-instruction writes and drives stall/flush/redirect.
module trap_seq
    import trap_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_data_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            irq_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic            csr_req_valid_i,
    input  logic [11:0]     csr_req_addr_i,
    input  logic [XLEN-1:0] csr_req_data_i,
    output logic            csr_req_ready_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            redirect_valid_o,
    output logic [5:0]      stall_o,
    output logic [5:0]      flush_o,
    output logic            busy_o
);

    trap_state_e state_q, state_d;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] status_q;
    logic [XLEN-1:0] tvec_q;      // mtvec for traps, mepc for mret
    logic            is_irq_q;
    logic            is_mret_q;

    logic            idle;
    logic            irq_take;
    logic            trap_ev;
    logic            mret_ev;
    logic            grant;
    logic [XLEN-1:0] trap_target;

    // Events and requests are only qualified in IDLE and never while reset is asserted.
    assign idle     = (state_q == ST_IDLE);
    assign irq_take = irq_i & csr_mstatus_i[MIE_BIT];
    assign trap_ev  = idle & ~rst & (irq_take | ecall_i);
    assign mret_ev  = idle & ~rst & mret_i & ~irq_take & ~ecall_i;
    assign grant    = idle & ~rst & csr_req_valid_i & ~trap_ev & ~mret_ev;

    trap_target_calc u_target (
        .mtvec  (tvec_q),
        .is_irq (is_irq_q),
        .target (trap_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            cause_q   <= '0;
            status_q  <= '0;
            tvec_q    <= '0;
            is_irq_q  <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trap_ev || mret_ev) begin
                pc_q      <= pc_i;
                inst_q    <= (trap_ev && ecall_i && !irq_take) ? inst_data_i : 32'd0;
                cause_q   <= irq_take ? CAUSE_MTI_INT : CAUSE_ECALL;
                status_q  <= csr_mstatus_i;
                tvec_q    <= mret_ev ? csr_mepc_i : csr_mtvec_i;
                is_irq_q  <= trap_ev & irq_take;
                is_mret_q <= mret_ev;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        csr_req_ready_o  = 1'b0;
        csr_we_o         = 1'b0;
        csr_waddr_o      = 12'd0;
        csr_wdata_o      = '0;
        redirect_pc_o    = '0;
        redirect_valid_o = 1'b0;
        stall_o          = 6'd0;
        flush_o          = 6'd0;
        busy_o           = ~idle;

        case (state_q)
            ST_IDLE: begin
                if (trap_ev) begin
                    state_d = ST_W_EPC;
                    stall_o = STALL_TRAP;
                end else if (mret_ev) begin
                    state_d = ST_R_STATUS;
                    stall_o = STALL_TRAP;
                end else if (grant) begin
                    csr_req_ready_o = 1'b1;
                    csr_we_o        = 1'b1;
                    csr_waddr_o     = csr_req_addr_i;
                    csr_wdata_o     = csr_req_data_i;
                end
            end
            ST_W_EPC: begin
                state_d     = ST_W_CAUSE;
                stall_o     = STALL_TRAP;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = pc_q;
            end
            ST_W_CAUSE: begin
                state_d     = ST_W_TVAL;
                stall_o     = STALL_TRAP;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            ST_W_TVAL: begin
                state_d     = ST_W_STATUS;
                stall_o     = STALL_TRAP;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = {32'd0, inst_q};
            end
            ST_W_STATUS: begin
                state_d     = ST_REDIRECT;
                stall_o     = STALL_TRAP;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = entry_status(status_q);
            end
            ST_R_STATUS: begin
                state_d     = ST_REDIRECT;
                stall_o     = STALL_TRAP;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_status(status_q);
            end
            ST_REDIRECT: begin
                state_d          = ST_IDLE;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = is_mret_q ? tvec_q : trap_target;
                flush_o          = FLUSH_REDIRECT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_seq.sv
// Randomised bench for trap_seq: drivers push expected CSR writes and redirects into queues,
// a negedge monitor pops and compares them whenever the DUT presents a write or redirect.
module tb_trap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_i = '0;
    logic [31:0] inst_data_i = '0;
    logic        ecall_i = 1'b0;
    logic        mret_i = 1'b0;
    logic        irq_i = 1'b0;
    logic [63:0] csr_mstatus_i = '0;
    logic [63:0] csr_mepc_i = '0;
    logic [63:0] csr_mtvec_i = '0;
    logic        csr_req_valid_i = 1'b0;
    logic [11:0] csr_req_addr_i = '0;
    logic [63:0] csr_req_data_i = '0;
    logic        csr_req_ready_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic [63:0] redirect_pc_o;
    logic        redirect_valid_o;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;
    logic        busy_o;

    trap_seq dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .inst_data_i      (inst_data_i),
        .ecall_i          (ecall_i),
        .mret_i           (mret_i),
        .irq_i            (irq_i),
        .csr_mstatus_i    (csr_mstatus_i),
        .csr_mepc_i       (csr_mepc_i),
        .csr_mtvec_i      (csr_mtvec_i),
        .csr_req_valid_i  (csr_req_valid_i),
        .csr_req_addr_i   (csr_req_addr_i),
        .csr_req_data_i   (csr_req_data_i),
        .csr_req_ready_o  (csr_req_ready_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_valid_o (redirect_valid_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // write entry: {cycle[15:0], addr[11:0], data[63:0]}; redirect entry: {cycle[15:0], pc[63:0]}
    logic [91:0] wr_q[$];
    logic [79:0] rd_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [191:0] all_outputs();
        return 192'({csr_req_ready_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_pc_o,
                     redirect_valid_o, stall_o, flush_o, busy_o});
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_entry_status(input logic [63:0] ms);
        logic [63:0] r;
        r = ms & ~64'h1888;
        if (ms[3]) r = r | 64'h80;
        return r | 64'h1800;
    endfunction

    function automatic logic [63:0] m_mret_status(input logic [63:0] ms);
        logic [63:0] r;
        r = ms & ~64'h1888;
        if (ms[7]) r = r | 64'h8;
        return r | 64'h1880;
    endfunction

    function automatic logic [63:0] m_target(input logic [63:0] mtvec, input bit is_irq);
        logic [63:0] base;
        base = mtvec - (mtvec % 4);
        if ((mtvec % 4) == 1 && is_irq) return base + 64'd28;
        return base;
    endfunction

    task automatic push_wr(input int c, input logic [11:0] a, input logic [63:0] d);
        wr_q.push_back({c[15:0], a, d});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [91:0] we;
        logic [79:0] re;
        if (csr_we_o) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write at cycle %0d: addr %0h data %0h, none expected",
                         cyc, csr_waddr_o, csr_wdata_o);
            end else begin
                we = wr_q.pop_front();
                check("csr_write", 192'({cyc[15:0], csr_waddr_o, csr_wdata_o}), 192'(we));
            end
        end
        if (redirect_valid_o) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_redirect at cycle %0d: pc %0h, none expected",
                         cyc, redirect_pc_o);
            end else begin
                re = rd_q.pop_front();
                check("redirect", 192'({cyc[15:0], redirect_pc_o}), 192'(re));
                check("redirect_ctl", 192'({stall_o, flush_o}), 192'({6'b000000, 6'b001110}));
            end
        end
        if (busy_o && !redirect_valid_o)
            check("busy_stall_flush", 192'({stall_o, flush_o}), 192'({6'b001111, 6'b000000}));
        if (busy_o && csr_req_valid_i)
            check("busy_req_ready", 192'(csr_req_ready_o), 192'(0));
    end

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        ecall_i = 0; mret_i = 0; irq_i = 0; csr_req_valid_i = 0;
        pc_i = '0; inst_data_i = '0; csr_mstatus_i = '0; csr_mepc_i = '0; csr_mtvec_i = '0;
        csr_req_addr_i = '0; csr_req_data_i = '0;
    endtask

    task automatic run_txn(input bit e, input bit m, input bit i, input bit r, input bit force_req,
                           input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] ms,
                           input logic [63:0] mepc, input logic [63:0] mtvec,
                           input logic [11:0] ra, input logic [63:0] rdat);
        bit irq_take, is_trap, is_mret, grant;
        int c, lat;
        @(posedge clk); #1;
        ecall_i = e; mret_i = m; irq_i = i; csr_req_valid_i = r;
        pc_i = pc; inst_data_i = inst; csr_mstatus_i = ms; csr_mepc_i = mepc; csr_mtvec_i = mtvec;
        csr_req_addr_i = ra; csr_req_data_i = rdat;
        c = cyc;
        irq_take = i && ms[3];
        is_trap  = irq_take || e;
        is_mret  = !is_trap && m;
        grant    = r && !is_trap && !m;
        lat = 0;
        if (grant) push_wr(c, ra, rdat);
        if (is_trap) begin
            push_wr(c + 1, 12'h341, pc);
            push_wr(c + 2, 12'h342, irq_take ? 64'h8000_0000_0000_0007 : 64'd11);
            push_wr(c + 3, 12'h343, irq_take ? 64'd0 : {32'd0, inst});
            push_wr(c + 4, 12'h300, m_entry_status(ms));
            rd_q.push_back({16'(c + 5), m_target(mtvec, irq_take)});
            lat = 5;
        end else if (is_mret) begin
            push_wr(c + 1, 12'h300, m_mret_status(ms));
            rd_q.push_back({16'(c + 2), mepc});
            lat = 2;
        end
        @(negedge clk);
        check("event_ready", 192'(csr_req_ready_o), 192'(grant));
        check("event_stall", 192'({stall_o, busy_o}),
              192'({(is_trap || is_mret) ? 6'b001111 : 6'b000000, 1'b0}));
        // noise while busy must not disturb the latched values or the sequence
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            ecall_i = 1'($urandom_range(0, 1));
            mret_i  = 1'($urandom_range(0, 1));
            irq_i   = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            csr_req_valid_i = force_req ? 1'b1 : 1'($urandom_range(0, 1));
            pc_i = {$urandom, $urandom};
            inst_data_i = $urandom;
            csr_mstatus_i = {$urandom, $urandom};
            csr_mepc_i = {$urandom, $urandom};
            csr_mtvec_i = {$urandom, $urandom};
            csr_req_addr_i = 12'($urandom);
            csr_req_data_i = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic rst_midseq_test();
        int c;
        @(posedge clk); #1;
        ecall_i = 1; pc_i = 64'h8000_0200; inst_data_i = 32'h0000_0073;
        csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h8000_0100;
        c = cyc;
        push_wr(c + 1, 12'h341, 64'h8000_0200);
        push_wr(c + 2, 12'h342, 64'd11);
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;          // W_CAUSE cycle
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_midseq_outputs", all_outputs(), 192'(0));
        repeat (7) @(posedge clk);
        check("rst_midseq_no_pending", 192'({wr_q.size(), rd_q.size()}), 192'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        ecall_i = 1; csr_req_valid_i = 1; irq_i = 1; csr_mstatus_i = 64'h8;
        @(negedge clk);
        check("reset_outputs", all_outputs(), 192'(0));
        @(posedge clk); #1;
        clear_inputs();
        rst = 0;
        @(negedge clk);
        check("post_reset_idle", all_outputs(), 192'(0));

        // directed cases
        run_txn(1, 0, 0, 0, 0, 64'h8000_0010, 32'h0000_0073, 64'h8, 0, 64'h8000_0100, 0, 0);
        run_txn(0, 1, 0, 0, 0, 64'h8000_0020, 32'h3020_0073, 64'h1880, 64'h8000_0014, 0, 0, 0);
        run_txn(0, 0, 1, 0, 0, 64'h8000_0030, 32'h1234_5678, 64'h8, 0, 64'h8000_0101, 0, 0);
        run_txn(0, 0, 1, 1, 0, 64'h8000_0040, 0, 64'h0, 0, 64'h8000_0101, 12'h305, 64'h1234);
        run_txn(1, 0, 1, 1, 0, 64'h8000_0050, 32'h0000_0073, 64'h8, 0, 64'h8000_0101,
                12'h305, 64'h5555);
        run_txn(0, 0, 0, 1, 0, 64'h8000_0060, 0, 0, 0, 0, 12'h305, 64'h1234);
        run_txn(1, 0, 0, 1, 1, 64'h8000_0070, 32'h0000_0073, 64'h8, 0, 64'h8000_0102,
                12'h305, 64'h1234);
        run_txn(0, 0, 1, 0, 0, 64'h8000_0080, 0, 64'h88, 0, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
        run_txn(1, 0, 0, 0, 0, 64'h8000_0090, 32'h0000_0073, 64'h0, 0, 64'h8000_0101, 0, 0);
        run_txn(0, 1, 0, 1, 0, 64'h8000_00A0, 0, 64'h0, 64'hFFFF_0000_1234_5678, 0,
                12'h340, 64'h77);
        rst_midseq_test();
        run_txn(1, 0, 0, 0, 0, 64'h8000_0300, 32'h0000_0073, 64'h8, 0, 64'h8000_0100, 0, 0);

        // randomised transactions
        for (int n = 0; n < 60; n++) begin
            bit e, m, i, r;
            logic [63:0] ms;
            logic [63:0] tv;
            e = 0; m = 0; i = 0; r = 0;
            case ($urandom_range(0, 5))
                0: e = 1;
                1: m = 1;
                2: i = 1;
                3: r = 1;
                4: begin
                    e = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
                    i = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
                end
                default: begin i = 1; r = 1; end
            endcase
            ms = {$urandom, $urandom};
            tv = {$urandom, $urandom};
            tv[1:0] = 2'($urandom_range(0, 3));
            run_txn(e, m, i, r, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, ms,
                    {$urandom, $urandom}, tv, 12'($urandom), {$urandom, $urandom});
        end

        repeat (8) @(posedge clk);
        check("write_queue_drained", 192'(wr_q.size()), 192'(0));
        check("redirect_queue_drained", 192'(rd_q.size()), 192'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
# trap_seq

Multi-cycle trap sequencer for the MEM stage. It serialises trap entry (ecall, machine timer interrupt) and mret into CSR writes over the core's single CSR write port. It also arbitrates that port against ordinary CSR-instruction writes, and drives pipeline stall/flush and the fetch redirect. It sits between the MEM stage, the CSR file and the IF-stage PC mux, and replaces the single-cycle combinational trap path.

## Interface
- `XLEN`, 64: datapath width, from `sysconfig.v`.
- `clk` input 1: core clock.
- `rst` input 1: reset; synchronous and active-high.
- `pc_i` input XLEN: PC of the instruction in MEM.
- `inst_data_i` input 32: instruction word in MEM.
- `ecall_i`, `mret_i` input 1 each: decoded trap events from MEM.
- `irq_i` input 1: machine timer interrupt pending (level).
- `csr_mstatus_i`, `csr_mepc_i`, `csr_mtvec_i` input XLEN: CSR read data.
- `csr_req_valid_i` input 1, `csr_req_addr_i` input 12, `csr_req_data_i` input XLEN: CSR-instruction write request.
- `csr_req_ready_o` output 1: write request accepted this cycle.
- `csr_we_o` output 1, `csr_waddr_o` output 12, `csr_wdata_o` output XLEN: the single CSR write port.
- `redirect_pc_o` output XLEN, `redirect_valid_o` output 1: fetch redirect.
- `stall_o` output 6, `flush_o` output 6: per-stage hold and NOP, bit order as in the rest of the pipeline.
- `busy_o` output 1: FSM not in IDLE.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT; the mret path is IDLE → R_STATUS → REDIRECT.
- Event qualification in IDLE:
  - `irq_take = irq_i & mstatus[3]` (MIE).
  - Priority: `irq_take` > `ecall_i` > `mret_i` > CSR request.
- On a trap event in IDLE, latch into registers:
  - `pc_i`.
  - `inst_data_i` (ecall only; 0 for irq).
  - mcause: 11 for ecall; `{1'b1, 59'b0, 4'd7}` for irq.
  - mstatus snapshot.
  - `mtvec`.
- Entry sequence (one write per state):
  - W_EPC: 0x341 ← pc.
  - W_CAUSE: 0x342 ← cause.
  - W_TVAL: 0x343 ← `{32'b0, inst}`.
  - W_STATUS: 0x300 ← snapshot with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11.
- mret sequence:
  - R_STATUS: 0x300 ← snapshot with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - Target is `csr_mepc_i`, latched in IDLE.
- Trap target:
  - `mtvec[1:0]` == 00: `{mtvec[XLEN-1:2], 2'b00}`.
  - `mtvec[1:0]` == 01 and interrupt: base + 4×7.
  - Arithmetic is XLEN-bit and wraps modulo 2^XLEN.
  - `mtvec[1:0]` ≥ 2 is treated as direct.
- REDIRECT:
  - `redirect_valid_o` = 1 and `redirect_pc_o` = target.
  - `flush_o` = 6'b001110, `stall_o` = 0.
  - Next state is IDLE.
- CSR request arbitration:
  - `csr_req_ready_o` = `csr_req_valid_i` & IDLE & no trap event that cycle.
  - When ready, the request passes to the write port in the same cycle.
  - If a trap event coincides with a request, the request is dropped and not retried. The MEM instruction is refetched from the saved mepc.
- `csr_we_o` is 1 only in W_* / R_STATUS states or on a granted request. At most one write per cycle.

## Timing
- Reset: state IDLE, all latches 0, every output 0.
- Trap detection cycle (IDLE, event seen):
  - `stall_o` = 6'b001111, combinational.
  - No CSR write in this cycle.
- W_* / R_STATUS states: `stall_o` = 6'b001111, `flush_o` = 0, `busy_o` = 1.
- Latency, event cycle to `redirect_valid_o`:
  - ecall/irq: 5 cycles (4 writes, then REDIRECT).
  - mret: 2 cycles.
- Events arriving while not IDLE are ignored. A still-pending `irq_i` is reevaluated in the first IDLE cycle after REDIRECT, against the updated mstatus.
- `rst` mid-sequence:
  - Next cycle is IDLE, outputs 0.
  - CSR writes already issued stay; no further writes or redirect occur.
- Granted CSR request: write on the same edge, zero added latency, no stall.

## Structure
- `sysconfig.v` holds shared defines:
  - `XLEN`.
  - CSR addresses 0x300/0x305/0x341/0x342/0x343.
  - Cause codes 11 and 7, and the interrupt bit position.
  - Stall/flush patterns 6'b001111 and 6'b001110.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11.
- Single module. Target computation (mode decode, vector add) is a natural combinational sub-module, `trap_target_calc`.

## Test plan
- ecall at pc 0x8000_0010, inst 0x0000_0073, mtvec 0x8000_0100, mstatus 0x8 → writes in order:
  - 0x341 ← 0x8000_0010.
  - 0x342 ← 11.
  - 0x343 ← 0x73.
  - 0x300 ← 0x1880.
  - Then redirect 0x8000_0100 with flush 6'b001110, 5 cycles after the event.
- mret with mepc 0x8000_0014, mstatus 0x1880 → 0x300 ← 0x1888, then redirect 0x8000_0014 two cycles after the event.
- irq with mtvec 0x8000_0101, mstatus MIE=1 → 0x342 ← 0x8000_0000_0000_0007, 0x343 ← 0, redirect 0x8000_011C. With MIE=0 → no action, ready path unaffected.
- irq, ecall and a CSR request in the same cycle:
  - irq taken, `csr_req_ready_o` = 0, no request write.
  - mcause = interrupt 7.
  - mepc = the ecall PC.
- CSR request 0x305 ← 0x1234 in IDLE → ready=1 and the write in the same cycle. Repeated while busy → ready=0 for all four W_* cycles.
- `rst` asserted during W_CAUSE → no W_TVAL/W_STATUS write, no redirect, all outputs 0 on the next cycle. A new ecall afterwards completes normally.
